// File: rtl/coherence_bus_arbiter.sv
// Round-robin snoop-bus arbiter and fill-source router for two cache controllers.
// Optional memory-wait watchdog and sticky bus_error port: define BUS_TIMEOUT_EN.
module coherence_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       read_miss,
  input  logic [1:0]       write_miss,
  input  logic [1:0]       invalidate,
  input  logic [1:0]       u_re,
  input  logic [1:0]       u_we,
  input  logic [1:0][12:0] BICO,
  input  logic [1:0]       cpu_search_found,
  input  logic [1:0][1:0]  block_state,
  input  logic [1:0][15:0] send_other_proc_data,
  input  logic             u_rdy,
  output logic [1:0]       grant,
  output logic [1:0][1:0]  cpu_datasel,
  output logic [1:0][12:0] BOCI,
  output logic [1:0]       cpu_search,
  output logic [1:0]       invalidate_from_other_cpu,
  output logic [1:0][15:0] other_proc_data,
`ifdef BUS_TIMEOUT_EN
  output logic             bus_error,
`endif
  output logic             bus_busy
);

  localparam logic [1:0] BS_SHARED   = 2'b01;
  localparam logic [1:0] BS_MODIFIED = 2'b10;
  localparam logic [1:0] SEL_DMEM    = 2'b00;
  localparam logic [1:0] SEL_OTHER   = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SNOOP    = 3'd1,
    S_RESP     = 3'd2,
    S_MEM_WAIT = 3'd3,
    S_INVAL    = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    RT_INV = 3'd0,
    RT_WM  = 3'd1,
    RT_RM  = 3'd2,
    RT_UWE = 3'd3,
    RT_URE = 3'd4
  } req_t;

  function automatic logic [1:0] core_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

  state_t            state_q, state_d;
  req_t              type_q, type_d;
  logic              rr_q, rr_d;
  logic              w_q, w_d;
  logic [12:0]       addr_q, addr_d;
  logic [1:0]        grant_q, grant_d;
  logic [1:0]        search_q, search_d;
  logic [1:0]        inval_q, inval_d;
  logic [1:0][1:0]   sel_q, sel_d;
  logic [1:0][12:0]  boci_q, boci_d;
  logic [1:0][15:0]  opd_q, opd_d;
  logic              busy_q, busy_d;
  logic [1:0]        req_s;
  logic              hit_s;

`ifdef BUS_TIMEOUT_EN
  localparam logic [7:0] TMO_LIM = 8'(TIMEOUT_CYC - 1);
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic       tmo_s;
`else
  localparam int unsigned unused_timeout_cyc = TIMEOUT_CYC;
`endif

  assign req_s = read_miss | write_miss | invalidate | u_re | u_we;

  // Arbitration and transaction sequencing.
  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    rr_d    = rr_q;
    w_d     = w_q;
    addr_d  = addr_q;
    hit_s   = 1'b0;
`ifdef BUS_TIMEOUT_EN
    tmo_s   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_s[rr_q] || req_s[~rr_q]) begin
          w_d    = req_s[rr_q] ? rr_q : ~rr_q;
          addr_d = BICO[w_d];
          if (invalidate[w_d]) begin
            type_d  = RT_INV;
            state_d = S_INVAL;
          end else if (write_miss[w_d]) begin
            type_d  = RT_WM;
            state_d = S_SNOOP;
          end else if (read_miss[w_d]) begin
            type_d  = RT_RM;
            state_d = S_SNOOP;
          end else if (u_we[w_d]) begin
            type_d  = RT_UWE;
            state_d = S_MEM_WAIT;
          end else begin
            type_d  = RT_URE;
            state_d = S_MEM_WAIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SNOOP: state_d = S_RESP;
      S_RESP: begin
        hit_s   = cpu_search_found[~w_q] &&
                  (block_state[~w_q] == BS_SHARED || block_state[~w_q] == BS_MODIFIED);
        state_d = hit_s ? S_DONE : S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        if (u_rdy) begin
          state_d = S_DONE;
`ifdef BUS_TIMEOUT_EN
        end else if (cnt_q == TMO_LIM) begin
          tmo_s   = 1'b1;
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_MEM_WAIT;
        end
      end
      S_INVAL: state_d = S_DONE;
      S_DONE: begin
        rr_d    = ~w_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output next-values, aligned so each registered strobe is high during its state.
  always_comb begin
    sel_d  = sel_q;
    boci_d = boci_q;
    opd_d  = opd_q;
    busy_d = (state_d != S_IDLE);
    if (state_d == S_DONE) begin
      grant_d = core_onehot(w_d);
    end else begin
      grant_d = 2'b00;
    end
    if (state_d == S_SNOOP) begin
      search_d = core_onehot(~w_d);
    end else begin
      search_d = 2'b00;
    end
    // A write miss invalidates the other copy in RESP whether or not the snoop hit.
    if (state_d == S_INVAL || (state_d == S_RESP && type_d == RT_WM)) begin
      inval_d = core_onehot(~w_d);
    end else begin
      inval_d = 2'b00;
    end
    if (state_d == S_SNOOP || state_d == S_INVAL) begin
      boci_d[~w_d] = addr_d;
    end else begin
      boci_d = boci_q;
    end
    if (state_q == S_RESP && hit_s) begin
      sel_d[w_q] = SEL_OTHER;
      opd_d[w_q] = send_other_proc_data[~w_q];
    end else if (state_d == S_MEM_WAIT) begin
      sel_d[w_d] = SEL_DMEM;
    end else begin
      sel_d = sel_q;
    end
  end

`ifdef BUS_TIMEOUT_EN
  // Watchdog counter next-state; bus_error is sticky until reset.
  always_comb begin
    if (state_q == S_MEM_WAIT) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = 8'd0;
    end
    err_d = err_q | tmo_s;
  end

  // Watchdog registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign bus_error = err_q;
`endif

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      type_q   <= RT_RM;
      rr_q     <= 1'b0;
      w_q      <= 1'b0;
      addr_q   <= 13'h0000;
      grant_q  <= 2'b00;
      search_q <= 2'b00;
      inval_q  <= 2'b00;
      sel_q    <= 4'h0;
      boci_q   <= 26'h0000000;
      opd_q    <= 32'h00000000;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      type_q   <= type_d;
      rr_q     <= rr_d;
      w_q      <= w_d;
      addr_q   <= addr_d;
      grant_q  <= grant_d;
      search_q <= search_d;
      inval_q  <= inval_d;
      sel_q    <= sel_d;
      boci_q   <= boci_d;
      opd_q    <= opd_d;
      busy_q   <= busy_d;
    end
  end

  assign grant                     = grant_q;
  assign cpu_search                = search_q;
  assign invalidate_from_other_cpu = inval_q;
  assign cpu_datasel               = sel_q;
  assign BOCI                      = boci_q;
  assign other_proc_data           = opd_q;
  assign bus_busy                  = busy_q;

endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// Self-checking bench for coherence_bus_arbiter: vector table with a scoreboard queue,
// plus hand sequences for contention, reset abort and (under BUS_TIMEOUT_EN) the watchdog.
module tb_coherence_bus_arbiter;

  localparam logic [1:0] BS_I = 2'b00;
  localparam logic [1:0] BS_S = 2'b01;
  localparam logic [1:0] BS_M = 2'b10;
  localparam int E_RM = 0, E_WM = 1, E_INV = 2, E_MEM = 3;
`ifdef BUS_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 255;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       read_miss, write_miss, invalidate, u_re, u_we, cpu_search_found;
  logic [1:0][12:0] BICO;
  logic [1:0][1:0]  block_state;
  logic [1:0][15:0] send_other_proc_data;
  logic             u_rdy;
  logic [1:0]       grant, cpu_search, invalidate_from_other_cpu;
  logic [1:0][1:0]  cpu_datasel;
  logic [1:0][12:0] BOCI;
  logic [1:0][15:0] other_proc_data;
  logic             bus_busy;
`ifdef BUS_TIMEOUT_EN
  logic             bus_error;
`endif

  coherence_bus_arbiter #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst),
    .read_miss(read_miss), .write_miss(write_miss), .invalidate(invalidate),
    .u_re(u_re), .u_we(u_we), .BICO(BICO),
    .cpu_search_found(cpu_search_found), .block_state(block_state),
    .send_other_proc_data(send_other_proc_data), .u_rdy(u_rdy),
    .grant(grant), .cpu_datasel(cpu_datasel), .BOCI(BOCI),
    .cpu_search(cpu_search), .invalidate_from_other_cpu(invalidate_from_other_cpu),
    .other_proc_data(other_proc_data),
`ifdef BUS_TIMEOUT_EN
    .bus_error(bus_error),
`endif
    .bus_busy(bus_busy)
  );

  always #5 clk = ~clk;

  // req bit order: {u_we, u_re, invalidate, write_miss, read_miss}
  typedef struct {
    logic        core;
    logic [4:0]  req;
    logic [12:0] addr;
    logic        found;
    logic [1:0]  bst;
    logic [15:0] sdata;
    int          rdy_at;
    logic        drop;
    int          eff;
    int          lat;
    logic [1:0]  ds;
  } vec_t;

  typedef struct {
    logic        core;
    int          lat;
    logic [1:0]  ds;
    logic [15:0] opd;
    logic [12:0] boci;
    int          scyc;
    int          icyc;
  } exp_t;

  exp_t        exp_q[$];
  vec_t        vecs[14];
  logic [15:0] opd_m[2];
  logic [12:0] boci_m[2];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic vec_t mk(logic c, logic [4:0] r, logic [12:0] a, logic f, logic [1:0] b,
                              logic [15:0] d, int ra, logic dr, int e, int l, logic [1:0] s);
    vec_t v;
    v.core = c; v.req = r; v.addr = a; v.found = f; v.bst = b; v.sdata = d;
    v.rdy_at = ra; v.drop = dr; v.eff = e; v.lat = l; v.ds = s;
    return v;
  endfunction

  task automatic clear_inputs();
    read_miss = 2'b00; write_miss = 2'b00; invalidate = 2'b00; u_re = 2'b00; u_we = 2'b00;
    cpu_search_found = 2'b00; block_state = 4'h0; BICO = 26'h0;
    send_other_proc_data = 32'h0; u_rdy = 1'b0;
  endtask

  task automatic drive_req(input logic c, input logic [4:0] m);
    read_miss[c] = m[0]; write_miss[c] = m[1]; invalidate[c] = m[2];
    u_re[c] = m[3]; u_we[c] = m[4];
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_grant"}, 32'(grant), 32'h0);
    chk({tag, "_search"}, 32'(cpu_search), 32'h0);
    chk({tag, "_inval"}, 32'(invalidate_from_other_cpu), 32'h0);
    chk({tag, "_datasel"}, 32'(cpu_datasel), 32'h0);
    chk({tag, "_boci"}, 32'(BOCI), 32'h0);
    chk({tag, "_opd"}, 32'(other_proc_data), 32'h0);
    chk({tag, "_busy"}, 32'(bus_busy), 32'h0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    exp_t e, got;
    logic oc, hit;
    int cyc, scyc, icyc, gcyc, bad;
    oc  = ~v.core;
    hit = (v.eff == E_RM || v.eff == E_WM) && v.found && (v.bst == BS_S || v.bst == BS_M);
    e.core = v.core; e.lat = v.lat; e.ds = v.ds;
    e.opd  = hit ? v.sdata : opd_m[v.core];
    e.boci = (v.eff == E_MEM) ? boci_m[oc] : v.addr;
    e.scyc = (v.eff == E_RM || v.eff == E_WM) ? 1 : -1;
    e.icyc = (v.eff == E_INV) ? 1 : ((v.eff == E_WM) ? 2 : -1);
    opd_m[v.core] = e.opd;
    boci_m[oc]    = e.boci;
    exp_q.push_back(e);
    BICO[v.core] = v.addr;
    cpu_search_found[oc] = v.found;
    block_state[oc] = v.bst;
    send_other_proc_data[oc] = v.sdata;
    drive_req(v.core, v.req);
    cyc = 0; scyc = -1; icyc = -1; gcyc = -1; bad = 0;
    while (gcyc < 0 && cyc < 40) begin
      @(posedge clk); #1; cyc++;
      if (cyc == 1) chk($sformatf("v%0d_busy_active", idx), 32'(bus_busy), 32'h1);
      if (cpu_search[oc]) begin if (scyc >= 0) bad++; scyc = cyc; end
      if (invalidate_from_other_cpu[oc]) begin if (icyc >= 0) bad++; icyc = cyc; end
      if (cpu_search[v.core] || invalidate_from_other_cpu[v.core] || grant[oc]) bad++;
      if (grant[v.core]) begin
        gcyc = cyc;
        drive_req(v.core, 5'b00000);
      end
      u_rdy = (cyc == v.rdy_at);
      if (v.drop && cyc == 1) drive_req(v.core, 5'b00000);
    end
    if (gcyc < 0) begin
      chk($sformatf("v%0d_grant_seen", idx), 32'h0, 32'h1);
      void'(exp_q.pop_front());
    end else begin
      got = exp_q.pop_front();
      chk($sformatf("v%0d_latency", idx), 32'(gcyc), 32'(got.lat));
      chk($sformatf("v%0d_datasel", idx), 32'(cpu_datasel[got.core]), 32'(got.ds));
      chk($sformatf("v%0d_other_data", idx), 32'(other_proc_data[got.core]), 32'(got.opd));
      chk($sformatf("v%0d_boci_other", idx), 32'(BOCI[~got.core]), 32'(got.boci));
      chk($sformatf("v%0d_search_cycle", idx), 32'(scyc), 32'(got.scyc));
      chk($sformatf("v%0d_inval_cycle", idx), 32'(icyc), 32'(got.icyc));
      chk($sformatf("v%0d_stray_strobes", idx), 32'(bad), 32'h0);
    end
    clear_inputs();
    @(posedge clk); #1;
    chk($sformatf("v%0d_busy_idle", idx), 32'(bus_busy), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    int g0, g1, cyc, ng;
    vecs[0]  = mk(1'b0, 5'b00001, 13'h0042, 1'b1, BS_S, 16'hBEEF,  1, 1'b0, E_RM,  3, 2'b01);
    vecs[1]  = mk(1'b1, 5'b00001, 13'h0123, 1'b0, BS_S, 16'h5555,  8, 1'b0, E_RM,  9, 2'b00);
    vecs[2]  = mk(1'b0, 5'b00010, 13'h1ABC, 1'b1, BS_M, 16'h1234, -1, 1'b0, E_WM,  3, 2'b01);
    vecs[3]  = mk(1'b1, 5'b00010, 13'h0777, 1'b0, BS_I, 16'h0000,  3, 1'b0, E_WM,  4, 2'b00);
    vecs[4]  = mk(1'b0, 5'b00100, 13'h0F0F, 1'b0, BS_I, 16'h0000, -1, 1'b0, E_INV, 2, 2'b01);
    vecs[5]  = mk(1'b1, 5'b01000, 13'h0ABC, 1'b0, BS_I, 16'h0000,  1, 1'b0, E_MEM, 2, 2'b00);
    vecs[6]  = mk(1'b0, 5'b10000, 13'h1111, 1'b0, BS_I, 16'h0000,  4, 1'b0, E_MEM, 5, 2'b00);
    vecs[7]  = mk(1'b1, 5'b00001, 13'h0002, 1'b1, BS_I, 16'hCAFE,  3, 1'b0, E_RM,  4, 2'b00);
    vecs[8]  = mk(1'b0, 5'b00001, 13'h0003, 1'b0, BS_M, 16'hD00D,  3, 1'b0, E_RM,  4, 2'b00);
    vecs[9]  = mk(1'b1, 5'b00001, 13'h1FFF, 1'b1, BS_M, 16'hFFFF, -1, 1'b1, E_RM,  3, 2'b01);
    vecs[10] = mk(1'b0, 5'b00100, 13'h0AAA, 1'b0, BS_I, 16'h0000, -1, 1'b1, E_INV, 2, 2'b00);
    vecs[11] = mk(1'b1, 5'b00111, 13'h0BBB, 1'b1, BS_S, 16'h7777, -1, 1'b0, E_INV, 2, 2'b01);
    vecs[12] = mk(1'b0, 5'b11010, 13'h0CCC, 1'b1, BS_S, 16'h4321, -1, 1'b0, E_WM,  3, 2'b01);
    vecs[13] = mk(1'b1, 5'b11000, 13'h0DDD, 1'b0, BS_I, 16'h0000,  2, 1'b0, E_MEM, 3, 2'b00);
    opd_m[0] = 16'h0; opd_m[1] = 16'h0; boci_m[0] = 13'h0; boci_m[1] = 13'h0;

    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

    // Contention: both cores miss together, twice; rr must come back to core 0 each time.
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    for (int rep = 0; rep < 2; rep++) begin
      read_miss = 2'b11; cpu_search_found = 2'b11; block_state = {BS_S, BS_S};
      BICO[0] = 13'h0100; BICO[1] = 13'h0200;
      send_other_proc_data[0] = 16'hB0B0 + 16'(rep);
      send_other_proc_data[1] = 16'hA1A1 + 16'(rep);
      g0 = -1; g1 = -1; cyc = 0;
      while ((g0 < 0 || g1 < 0) && cyc < 30) begin
        @(posedge clk); #1; cyc++;
        if (grant[0]) begin g0 = cyc; read_miss[0] = 1'b0; end
        if (grant[1]) begin g1 = cyc; read_miss[1] = 1'b0; end
      end
      chk($sformatf("both_r%0d_grant0_cycle", rep), 32'(g0), 32'd3);
      chk($sformatf("both_r%0d_grant1_cycle", rep), 32'(g1), 32'd7);
      chk($sformatf("both_r%0d_datasel", rep), 32'(cpu_datasel), 32'h5);
      chk($sformatf("both_r%0d_opd0", rep), 32'(other_proc_data[0]), 32'h0000A1A1 + 32'(rep));
      chk($sformatf("both_r%0d_opd1", rep), 32'(other_proc_data[1]), 32'h0000B0B0 + 32'(rep));
      chk($sformatf("both_r%0d_boci1", rep), 32'(BOCI[1]), 32'h0100);
      chk($sformatf("both_r%0d_boci0", rep), 32'(BOCI[0]), 32'h0200);
      clear_inputs();
      @(posedge clk); #1;
    end

    // Reset while waiting on memory aborts the transaction without a grant.
    u_re[0] = 1'b1; BICO[0] = 13'h0555;
    @(posedge clk); #1;
    chk("rstmw_busy", 32'(bus_busy), 32'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("rstmw");
    rst = 1'b0; u_re[0] = 1'b0; u_rdy = 1'b1;
    ng = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      u_rdy = 1'b0;
      if (grant != 2'b00) ng++;
    end
    chk("rstmw_no_grant", 32'(ng), 32'h0);
    opd_m[0] = 16'h0; opd_m[1] = 16'h0; boci_m[0] = 13'h0; boci_m[1] = 13'h0;

`ifdef BUS_TIMEOUT_EN
    // Watchdog: memory never answers.
    chk("tmo_error_before", 32'(bus_error), 32'h0);
    u_re[1] = 1'b1;
    g1 = -1; cyc = 0;
    while (g1 < 0 && cyc < 40) begin
      @(posedge clk); #1; cyc++;
      if (grant[1]) begin g1 = cyc; u_re[1] = 1'b0; end
    end
    chk("tmo_grant_cycle", 32'(g1), 32'd9);
    chk("tmo_error_set", 32'(bus_error), 32'h1);
    chk("tmo_datasel", 32'(cpu_datasel[1]), 32'h0);
    @(posedge clk); #1;
    chk("tmo_idle", 32'(bus_busy), 32'h0);
    chk("tmo_error_sticky", 32'(bus_error), 32'h1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
